load_store_unit: RTL and testbench

- Sits between the execute/memory pipeline stage and the word-organised data memory.
- Accepts byte, halfword and word load/store requests on a byte address, using a valid/ready handshake.
- Drives the memory's 14-bit word address, write enable and write data. Sub-word stores are done as read-modify-write, because the memory only writes whole words.
- Returns sign- or zero-extended load data, and flags misaligned accesses without touching memory.

---
 rtl/load_store_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the execute/memory stage to a word-organised data memory.
//   Accepts byte/half/word loads and stores on a byte address through a
//   valid/ready handshake. Sub-word stores are performed as
//   read-modify-write because the memory only writes whole words.
//   Misaligned or illegal-size requests complete with resp_err=1 and never
//   write memory.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   req_valid/ready : request handshake (ready only while idle)
//   req_write       : 1=store, 0=load
//   req_size        : 00=byte, 01=half, 10=word, 11=illegal
//   req_unsigned    : loads only, 1=zero-extend, 0=sign-extend
//   req_addr        : byte address
//   req_wdata       : right-aligned store data
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : extended load data (0 for stores and errors)
//   resp_err        : misaligned/illegal flag, qualified by resp_valid
//   mem_addr/we     : memory word address and write enable
//   mem_wdata       : full word written to memory
//   mem_rdata       : memory read data, one cycle after mem_addr
module load_store_unit #(
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [1:0]        off_q, off_d;
  // Only the low half of store data is ever needed after accept; full-word
  // stores take req_wdata straight into mem_wdata at the accept edge.
  logic [15:0]       wdata_q, wdata_d;
  logic              err_s;

  // Half needs bit 0 clear, word needs both low bits clear, size 11 is illegal.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lo[0];
      SIZE_WORD: bad = (lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed lane (little-endian) and sign/zero extend it.
  function automatic logic [31:0] extend_load(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace only the target lane of the old word; other lanes pass through.
  function automatic logic [31:0] merge_store(input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] word,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          2'b11:   r[31:24] = wd[7:0];
          default: r[7:0]   = wd[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) begin
          r[31:16] = wd;
        end else begin
          r[15:0] = wd;
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

  // Next-state and datapath decode; response fields change only when
  // entering RESP so they hold between responses.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    err_s        = is_misaligned(req_size, req_addr[1:0]);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata[15:0];
          mem_addr_d = req_addr[ADDR_W-1:2];
          if (err_s) begin
            state_d      = RESP;
            resp_rdata_d = 32'h0000_0000;
            resp_err_d   = 1'b1;
          end else if (req_write && (req_size == SIZE_WORD)) begin
            state_d     = WRITE;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = MERGE;
      end
      MERGE: begin
        if (write_q) begin
          mem_wdata_d = merge_store(size_q, off_q, mem_rdata, wdata_q);
          state_d     = WRITE;
        end else begin
          resp_rdata_d = extend_load(size_q, unsigned_q, off_q, mem_rdata);
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end
      end
      WRITE: begin
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= {MEM_AW{1'b0}};
      mem_wdata_q  <= 32'h0000_0000;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
    end
  end

  // Handshake and write strobe come straight from the state register.
  assign req_ready  = (state_q == IDLE);
  assign mem_we     = (state_q == WRITE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural synchronous
// word memory. Cycle numbers below count negedges after the accept edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:16383];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Synchronous word memory: registered read, whole-word write.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request; watches 8 cycles after accept for mem_we and resp_valid.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz,
                      input logic un, input logic [15:0] addr,
                      input logic [31:0] wd, input int exp_we_cyc,
                      input logic [31:0] exp_wdata, input int exp_resp_cyc,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int we_cyc, we_n, resp_cyc, resp_n, addr_bad;
    logic [31:0] got_wd, got_rd;
    logic got_err;
    we_cyc = -1; we_n = 0; resp_cyc = -1; resp_n = 0; addr_bad = 0;
    got_wd = 32'h0; got_rd = 32'h0; got_err = 1'b0;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = un; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_addr !== addr[15:2]) addr_bad++;
      if (mem_we) begin
        we_n++;
        if (we_cyc < 0) begin
          we_cyc = c;
          got_wd = mem_wdata;
        end
      end
      if (resp_valid) begin
        resp_n++;
        if (resp_cyc < 0) begin
          resp_cyc = c;
          got_rd = resp_rdata;
          got_err = resp_err;
        end
      end
    end
    check({tag, "_addr_held"}, addr_bad, 32'd0);
    check({tag, "_we_cycle"}, we_cyc, exp_we_cyc);
    check({tag, "_we_count"}, we_n, (exp_we_cyc < 0) ? 32'd0 : 32'd1);
    if (exp_we_cyc > 0) check({tag, "_wdata"}, got_wd, exp_wdata);
    check({tag, "_resp_cycle"}, resp_cyc, exp_resp_cyc);
    check({tag, "_resp_count"}, resp_n, 32'd1);
    check({tag, "_rdata"}, got_rd, exp_rdata);
    check({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
  endtask

  initial begin
    int we_seen, resp_seen;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 16'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    // Word stores (also preload words 4 and 5)
    xact("wst_dead", 1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 1, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    check("mem4_dead", mem[4], 32'hDEADBEEF);
    xact("wst_80ff", 1'b1, 2'b10, 1'b0, 16'h0010, 32'h80FF7F01, 1, 32'h80FF7F01, 2, 32'h0, 1'b0);
    xact("wst_1122", 1'b1, 2'b10, 1'b0, 16'h0014, 32'h11223344, 1, 32'h11223344, 2, 32'h0, 1'b0);

    // Loads from word 4 = 0x80FF7F01
    xact("lb_s_12", 1'b0, 2'b00, 1'b0, 16'h0012, 32'h0, -1, 32'h0, 3, 32'hFFFFFFFF, 1'b0);
    xact("lb_u_10", 1'b0, 2'b00, 1'b1, 16'h0010, 32'h0, -1, 32'h0, 3, 32'h00000001, 1'b0);
    xact("lb_s_11", 1'b0, 2'b00, 1'b0, 16'h0011, 32'h0, -1, 32'h0, 3, 32'h0000007F, 1'b0);
    xact("lb_u_13", 1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, -1, 32'h0, 3, 32'h00000080, 1'b0);
    xact("lh_s_12", 1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, -1, 32'h0, 3, 32'hFFFF80FF, 1'b0);
    xact("lh_u_12", 1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, -1, 32'h0, 3, 32'h000080FF, 1'b0);
    xact("lh_s_10", 1'b0, 2'b01, 1'b0, 16'h0010, 32'h0, -1, 32'h0, 3, 32'h00007F01, 1'b0);
    xact("lw_u_10", 1'b0, 2'b10, 1'b1, 16'h0010, 32'h0, -1, 32'h0, 3, 32'h80FF7F01, 1'b0);

    // Sub-word stores into word 5 = 0x11223344
    xact("sb_15", 1'b1, 2'b00, 1'b0, 16'h0015, 32'h123456AA, 3, 32'h1122AA44, 4, 32'h0, 1'b0);
    check("mem5_sb", mem[5], 32'h1122AA44);
    xact("sh_16", 1'b1, 2'b01, 1'b0, 16'h0016, 32'h5555BEEF, 3, 32'hBEEFAA44, 4, 32'h0, 1'b0);
    xact("sb_17", 1'b1, 2'b00, 1'b0, 16'h0017, 32'h00000077, 3, 32'h77EFAA44, 4, 32'h0, 1'b0);
    xact("sb_14", 1'b1, 2'b00, 1'b0, 16'h0014, 32'hFFFFFF01, 3, 32'h77EFAA01, 4, 32'h0, 1'b0);
    xact("sh_14", 1'b1, 2'b01, 1'b0, 16'h0014, 32'hABCD1234, 3, 32'h77EF1234, 4, 32'h0, 1'b0);
    xact("lw_14", 1'b0, 2'b10, 1'b0, 16'h0014, 32'h0, -1, 32'h0, 3, 32'h77EF1234, 1'b0);

    // Misaligned / illegal
    xact("err_lh_03", 1'b0, 2'b01, 1'b0, 16'h0003, 32'h0, -1, 32'h0, 1, 32'h0, 1'b1);
    xact("err_sw_02", 1'b1, 2'b10, 1'b0, 16'h0002, 32'hFFFFFFFF, -1, 32'h0, 1, 32'h0, 1'b1);
    xact("err_sz11_l", 1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, -1, 32'h0, 1, 32'h0, 1'b1);
    xact("err_sz11_s", 1'b1, 2'b11, 1'b0, 16'h0014, 32'h99999999, -1, 32'h0, 1, 32'h0, 1'b1);
    check("mem4_after_err", mem[4], 32'h80FF7F01);
    check("mem5_after_err", mem[5], 32'h77EF1234);
    check("mem0_after_err", mem[0] === 32'h99999999 || mem[0] === 32'hFFFFFFFF, 32'd0);

    // Reset during MERGE of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 16'h0014; req_wdata = 32'h000000CC;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);                 // READ
    @(negedge clk);                 // MERGE
    check("rstm_we_merge", {31'd0, mem_we}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstm_ready", {31'd0, req_ready}, 32'd1);
    check("rstm_mem_addr", {18'd0, mem_addr}, 32'd0);
    check("rstm_wdata", mem_wdata, 32'd0);
    check("rstm_rdata", resp_rdata, 32'd0);
    we_seen = 0; resp_seen = 0;
    if (mem_we) we_seen++;
    if (resp_valid) resp_seen++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (resp_valid) resp_seen++;
    end
    check("rstm_no_we", we_seen, 32'd0);
    check("rstm_no_resp", resp_seen, 32'd0);
    check("rstm_mem5", mem[5], 32'h77EF1234);

    // Back-to-back with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 16'h0020; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_write = 1'b0;            // next request: word load, valid kept high
    @(negedge clk);                 // cycle 1: WRITE
    check("b2b_c1_we", {31'd0, mem_we}, 32'd1);
    check("b2b_c1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);                 // cycle 2: first response
    check("b2b_c2_resp", {31'd0, resp_valid}, 32'd1);
    check("b2b_c2_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);                 // cycle 3: idle, second request accepted
    check("b2b_c3_ready", {31'd0, req_ready}, 32'd1);
    check("b2b_c3_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);                 // READ
    check("b2b_c4_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);                 // MERGE
    check("b2b_c5_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);                 // RESP
    check("b2b_c6_resp", {31'd0, resp_valid}, 32'd1);
    check("b2b_c6_rdata", resp_rdata, 32'hCAFEF00D);
    check("b2b_c6_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    check("b2b_c7_ready", {31'd0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
